// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: clock divider, h/v counters,
// registered sync/blank/position outputs and line/frame start strobes.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int POS_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             vga_clk,
  output logic             pix_ce,
  output logic             h_sync,
  output logic             v_sync,
  output logic             blank_n,
  output logic             sync_n,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = POS_W + 1;

  if ((H_TOTAL - 1) >= (1 << POS_W)) begin : g_bad_h
    $error("vga_timing_gen: H_TOTAL-1 does not fit in POS_W bits");
  end
  if ((V_TOTAL - 1) >= (1 << POS_W)) begin : g_bad_v
    $error("vga_timing_gen: V_TOTAL-1 does not fit in POS_W bits");
  end
  if ((CLK_DIV % 2) != 0 || CLK_DIV < 2 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be even and within 2..16");
  end

  localparam logic [POS_W-1:0] H_LAST   = POS_W'(H_TOTAL - 1);
  localparam logic [POS_W-1:0] V_LAST   = POS_W'(V_TOTAL - 1);
  // One extra bit so thresholds equal to 2**POS_W do not alias to zero.
  localparam logic [XW-1:0]    H_ACT_END = XW'(H_ACTIVE);
  localparam logic [XW-1:0]    HS_START  = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0]    HS_END    = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [XW-1:0]    V_ACT_END = XW'(V_ACTIVE);
  localparam logic [XW-1:0]    VS_START  = XW'(V_ACTIVE + V_FP);
  localparam logic [XW-1:0]    VS_END    = XW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [3:0]       DIV_LAST  = 4'(CLK_DIV - 1);
  localparam logic [3:0]       DIV_HALF  = 4'(CLK_DIV / 2);
  localparam logic             HS_ON     = (HS_POL != 0);
  localparam logic             VS_ON     = (VS_POL != 0);

  logic [3:0]       div_cnt;
  logic [3:0]       div_next;
  logic [POS_W-1:0] x_next;
  logic [POS_W-1:0] y_next;
  logic [XW-1:0]    xe;
  logic [XW-1:0]    ye;

  assign sync_n = 1'b0;

  always_comb begin
    pix_ce   = en && (div_cnt == DIV_LAST);
    div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + 4'd1;
    x_next   = pos_x;
    y_next   = pos_y;
    if (pix_ce) begin
      if (pos_x == H_LAST) begin
        x_next = '0;
        y_next = (pos_y == V_LAST) ? '0 : pos_y + POS_W'(1);
      end else begin
        x_next = pos_x + POS_W'(1);
      end
    end
    xe = {1'b0, x_next};
    ye = {1'b0, y_next};
  end

  // Sync/blank are derived from the next counter values so they stay aligned with pos_x/pos_y.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt     <= '0;
      vga_clk     <= 1'b0;
      pos_x       <= H_LAST;
      pos_y       <= V_LAST;
      blank_n     <= 1'b0;
      h_sync      <= ~HS_ON;
      v_sync      <= ~VS_ON;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      div_cnt     <= div_next;
      vga_clk     <= (div_next >= DIV_HALF);
      pos_x       <= x_next;
      pos_y       <= y_next;
      blank_n     <= (xe < H_ACT_END) && (ye < V_ACT_END);
      h_sync      <= ((xe >= HS_START) && (xe < HS_END)) ? HS_ON : ~HS_ON;
      v_sync      <= ((ye >= VS_START) && (ye < VS_END)) ? VS_ON : ~VS_ON;
      line_start  <= pix_ce && (x_next == '0);
      frame_start <= pix_ce && (x_next == '0) && (y_next == '0);
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default horizontal timing with a short frame, plus a tiny
// active-high-sync raster checked cycle by cycle against a closed-form model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic ra, ea, rb, eb;
  logic a_vga_clk, a_pix_ce, a_h_sync, a_v_sync, a_blank_n, a_sync_n, a_line_start, a_frame_start;
  logic [9:0] a_pos_x, a_pos_y;
  logic b_vga_clk, b_pix_ce, b_h_sync, b_v_sync, b_blank_n, b_sync_n, b_line_start, b_frame_start;
  logic [9:0] b_pos_x, b_pos_y;

  int checks = 0;
  int errors = 0;

  vga_timing_gen #(
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_a (
    .clk(clk), .rst(ra), .en(ea),
    .vga_clk(a_vga_clk), .pix_ce(a_pix_ce), .h_sync(a_h_sync), .v_sync(a_v_sync),
    .blank_n(a_blank_n), .sync_n(a_sync_n), .pos_x(a_pos_x), .pos_y(a_pos_y),
    .line_start(a_line_start), .frame_start(a_frame_start)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(4), .HS_POL(1), .VS_POL(1)
  ) dut_b (
    .clk(clk), .rst(rb), .en(eb),
    .vga_clk(b_vga_clk), .pix_ce(b_pix_ce), .h_sync(b_h_sync), .v_sync(b_v_sync),
    .blank_n(b_blank_n), .sync_n(b_sync_n), .pos_x(b_pos_x), .pos_y(b_pos_y),
    .line_start(b_line_start), .frame_start(b_frame_start)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] avec();
    return {37'd0, a_vga_clk, a_pix_ce, a_h_sync, a_v_sync, a_blank_n,
            a_line_start, a_frame_start, a_pos_x, a_pos_y};
  endfunction

  function automatic logic [63:0] bvec();
    return {37'd0, b_vga_clk, b_pix_ce, b_h_sync, b_v_sync, b_blank_n,
            b_line_start, b_frame_start, b_pos_x, b_pos_y};
  endfunction

  // n = clk edges since reset release; raster is 8x6, 4 clk per pixel.
  function automatic logic [63:0] bmodel(input int n);
    int a, l, x, y;
    logic vc, pc, hs, vs, bl, ls, fs;
    a = n / 4;
    if (a == 0) begin
      x = 7; y = 5;
    end else begin
      l = (a - 1) % 48;
      x = l % 8;
      y = l / 8;
    end
    vc = (n % 4) >= 2;
    pc = (n % 4) == 3;
    ls = (n > 0) && (n % 4 == 0) && (x == 0);
    fs = ls && (y == 0);
    bl = (x < 4) && (y < 3);
    hs = (x >= 5) && (x < 7);
    vs = (y == 4);
    return {37'd0, vc, pc, hs, vs, bl, ls, fs, 10'(x), 10'(y)};
  endfunction

  initial begin
    int n, bcnt, hcnt, hmin, hmax, fcnt, cyc, vcnt, vmin, vmax, blines;
    bit found;

    ra = 1'b0; ea = 1'b1; rb = 1'b0; eb = 1'b1;
    repeat (3) tick();

    chk("a_reset_state", avec(), {37'd0, 7'b0011000, 10'd799, 10'd14});
    chk("a_sync_n", a_sync_n, 0);

    // Release: vga_clk rises, then the first pix_ce edge lands the raster on (0,0).
    ra = 1'b1;
    tick();
    chk("a_rel_edge1", avec(), {37'd0, 7'b1111000, 10'd799, 10'd14});
    tick();
    chk("a_rel_edge2", avec(), {37'd0, 7'b0011111, 10'd0, 10'd0});

    // One full line at default horizontal timing.
    n = 1; bcnt = 1; hcnt = 0; hmin = 9999; hmax = -1; fcnt = 1; found = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (a_line_start) begin found = 1; break; end
      n++;
      if (a_blank_n) bcnt++;
      if (!a_h_sync) begin
        hcnt++;
        if (int'(a_pos_x) < hmin) hmin = int'(a_pos_x);
        if (int'(a_pos_x) > hmax) hmax = int'(a_pos_x);
      end
      if (a_frame_start) fcnt++;
    end
    chk("line_start_seen", found, 1);
    chk("line_clks", n, 1600);
    chk("blank_n_high_clks", bcnt, 1280);
    chk("h_sync_low_clks", hcnt, 192);
    chk("h_sync_first_x", hmin, 656);
    chk("h_sync_last_x", hmax, 751);
    chk("frame_start_single", fcnt, 1);
    chk("line1_pos", {a_pos_x, a_pos_y}, {10'd0, 10'd1});

    // Rest of the frame: 15 lines of 800 pixels.
    cyc = 1600; vcnt = 0; vmin = 9999; vmax = -1; blines = 0; found = 0;
    for (int i = 0; i < 30000; i++) begin
      if (!a_v_sync) vcnt++;
      if (a_line_start) begin
        if (!a_blank_n) blines++;
        if (!a_v_sync) begin
          if (int'(a_pos_y) < vmin) vmin = int'(a_pos_y);
          if (int'(a_pos_y) > vmax) vmax = int'(a_pos_y);
        end
      end
      tick();
      cyc++;
      if (a_frame_start) begin found = 1; break; end
    end
    chk("frame_start_seen", found, 1);
    chk("frame_clks", cyc, 24000);
    chk("v_sync_low_clks", vcnt, 3200);
    chk("v_sync_first_line", vmin, 10);
    chk("v_sync_last_line", vmax, 11);
    chk("blank_lines", blines, 7);
    chk("frame_wrap_pos", {a_pos_x, a_pos_y}, {10'd0, 10'd0});

    // Drop en exactly when pix_ce is high: the pending advance must not happen.
    repeat (201) tick();
    chk("pre_pause", avec(), {37'd0, 7'b1111100, 10'd100, 10'd0});
    ea = 1'b0;
    #1;
    chk("pause_pix_ce", a_pix_ce, 0);
    for (int i = 0; i < 37; i++) begin
      tick();
      chk("pause_hold", avec(), {37'd0, 7'b1011100, 10'd100, 10'd0});
    end
    ea = 1'b1;
    #1;
    chk("resume_pix_ce", a_pix_ce, 1);
    tick();
    chk("resume_advance", avec(), {37'd0, 7'b0011100, 10'd101, 10'd0});
    n = 0; found = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      n++;
      if (a_line_start) begin found = 1; break; end
    end
    chk("resume_line_seen", found, 1);
    chk("resume_to_line_clks", n, 1398);
    chk("resume_line_y", a_pos_y, 1);

    // Reset mid-line.
    found = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (a_pos_x == 10'd700) begin found = 1; break; end
    end
    chk("reach_x700", found, 1);
    ra = 1'b0;
    tick();
    chk("midline_reset", avec(), {37'd0, 7'b0011000, 10'd799, 10'd14});
    ra = 1'b1;
    tick();
    chk("restart_edge1", avec(), {37'd0, 7'b1111000, 10'd799, 10'd14});
    tick();
    chk("restart_edge2", avec(), {37'd0, 7'b0011111, 10'd0, 10'd0});

    // Small active-high raster, two frames against the model.
    chk("b_reset", bvec(), bmodel(0));
    chk("b_sync_n", b_sync_n, 0);
    rb = 1'b1;
    for (int k = 1; k <= 392; k++) begin
      tick();
      chk("b_model", bvec(), bmodel(k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
